// File: rtl/inv_mix_column_engine.sv
// inv_mix_column_engine: sequential AES InvMixColumns for one 32-bit column using four GF(2^8) multiplier ROMs
// Ports:
//   CLK, RST                       clock, asynchronous active-high reset
//   In_Valid/In_Ready/In_Column    upstream handshake and column s0..s3 (s0 = [31:24])
//   Out_Valid/Out_Ready/Out_Column downstream handshake and result r0..r3 (r0 = [31:24])
//   MulN_Read_Enable/Address/Data  read ports of the x9/x11/x13/x14 ROMs (1-cycle registered read)
module inv_mix_column_engine (
    input  logic        CLK,
    input  logic        RST,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [31:0] In_Column,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Out_Column,
    output logic        Mul9_Read_Enable,
    output logic        Mul11_Read_Enable,
    output logic        Mul13_Read_Enable,
    output logic        Mul14_Read_Enable,
    output logic [7:0]  Mul9_Read_Address,
    output logic [7:0]  Mul11_Read_Address,
    output logic [7:0]  Mul13_Read_Address,
    output logic [7:0]  Mul14_Read_Address,
    input  logic [7:0]  Mul9_Read_Data,
    input  logic [7:0]  Mul11_Read_Data,
    input  logic [7:0]  Mul13_Read_Data,
    input  logic [7:0]  Mul14_Read_Data
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] col_q, col_d;
    logic [1:0]  k_q, k_d;
    logic        cap_v_q;
    logic [1:0]  cap_k_q;
    logic [31:0] out_q, out_d;
    logic        issue;

    // byte i of a column, with s0 in the top byte; ~i gives 3-i for a 2-bit index
    function automatic logic [7:0] col_byte(input logic [31:0] c, input logic [1:0] i);
        return c[{~i, 3'b000} +: 8];
    endfunction

    assign issue      = state_q == ISSUE;
    assign In_Ready   = state_q == IDLE;
    assign Out_Valid  = state_q == DONE;
    assign Out_Column = out_q;

    assign Mul9_Read_Enable   = issue;
    assign Mul11_Read_Enable  = issue;
    assign Mul13_Read_Enable  = issue;
    assign Mul14_Read_Enable  = issue;
    assign Mul14_Read_Address = issue ? col_byte(col_q, k_q)         : 8'h00;
    assign Mul11_Read_Address = issue ? col_byte(col_q, k_q + 2'd1) : 8'h00;
    assign Mul13_Read_Address = issue ? col_byte(col_q, k_q + 2'd2) : 8'h00;
    assign Mul9_Read_Address  = issue ? col_byte(col_q, k_q + 2'd3) : 8'h00;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        k_d     = k_q;
        out_d   = out_q;
        if (state_q == IDLE && In_Valid) begin
            state_d = ISSUE;
            col_d   = In_Column;
            k_d     = 2'd0;
        end
        if (issue) begin
            k_d     = k_q + 2'd1;
            state_d = (k_q == 2'd3) ? DRAIN : ISSUE;
        end
        if (state_q == DRAIN) state_d = DONE;
        if (state_q == DONE && Out_Ready) state_d = IDLE;
        // products for the row issued last cycle are on Read_Data now
        if (cap_v_q) out_d[{~cap_k_q, 3'b000} +: 8] = Mul9_Read_Data ^ Mul11_Read_Data ^ Mul13_Read_Data ^ Mul14_Read_Data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            col_q   <= '0;
            k_q     <= '0;
            cap_v_q <= 1'b0;
            cap_k_q <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            k_q     <= k_d;
            cap_v_q <= issue;
            cap_k_q <= k_q;
            out_q   <= out_d;
        end
    end
endmodule

// File: tb/tb_inv_mix_column_engine.sv
// tb_inv_mix_column_engine: table-driven scoreboard bench for inv_mix_column_engine with behavioural multiplier ROMs
module tb_inv_mix_column_engine;
    logic        CLK, RST, In_Valid, In_Ready, Out_Valid, Out_Ready;
    logic [31:0] In_Column, Out_Column;
    logic        en9, en11, en13, en14;
    logic [7:0]  a9, a11, a13, a14, d9, d11, d13, d14;

    typedef struct {
        logic [31:0] c;
        logic [31:0] e;
    } vec_t;

    vec_t        tbl[6];
    logic [31:0] exp_q[$];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    int          acc[3];

    inv_mix_column_engine dut (
        .CLK(CLK), .RST(RST),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Column(In_Column),
        .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Column(Out_Column),
        .Mul9_Read_Enable(en9), .Mul11_Read_Enable(en11),
        .Mul13_Read_Enable(en13), .Mul14_Read_Enable(en14),
        .Mul9_Read_Address(a9), .Mul11_Read_Address(a11),
        .Mul13_Read_Address(a13), .Mul14_Read_Address(a14),
        .Mul9_Read_Data(d9), .Mul11_Read_Data(d11),
        .Mul13_Read_Data(d13), .Mul14_Read_Data(d14)
    );

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb(input logic [31:0] c, input int i);
        return c[8 * (3 - (i % 4)) +: 8];
    endfunction

    function automatic logic [31:0] inv_mix(input logic [31:0] c);
        logic [31:0] r;
        for (int k = 0; k < 4; k++)
            r[8 * (3 - k) +: 8] = gm(sb(c, k), 8'd14) ^ gm(sb(c, k + 1), 8'd11) ^ gm(sb(c, k + 2), 8'd13) ^ gm(sb(c, k + 3), 8'd9);
        return r;
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] c, input int i);
        return {sb(c, i), sb(c, i + 1), sb(c, i + 2), sb(c, i + 3)};
    endfunction

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        d9  <= en9  ? gm(a9, 8'd9)   : 8'h00;
        d11 <= en11 ? gm(a11, 8'd11) : 8'h00;
        d13 <= en13 ? gm(a13, 8'd13) : 8'h00;
        d14 <= en14 ? gm(a14, 8'd14) : 8'h00;
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        nvec++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic pop_check;
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("out_column", Out_Column, exp_q.pop_front());
    endtask

    // accepts a column from IDLE, traces the ROM ports, and leaves the bench just after E5
    task automatic send(input logic [31:0] c, input logic [31:0] e);
        chk("in_ready_idle", In_Ready, 1);
        In_Valid = 1'b1;
        In_Column = c;
        tick;
        exp_q.push_back(e);
        In_Valid = 1'b0;
        In_Column = $urandom;
        for (int i = 0; i < 4; i++) begin
            chk("enables_issue", {en14, en11, en13, en9}, 4'hf);
            chk("addresses_row", {a14, a11, a13, a9}, rotl(c, i));
            chk("out_valid_issue", Out_Valid, 0);
            tick;
        end
        chk("enables_drain", {en14, en11, en13, en9}, 4'h0);
        chk("out_valid_drain", Out_Valid, 0);
        tick;
        chk("out_valid_latency", Out_Valid, 1);
        chk("enables_done", {en14, en11, en13, en9}, 4'h0);
    endtask

    initial begin
        int w;
        tbl[0] = '{32'h8E4DA1BC, 32'hDB135345};
        tbl[1] = '{32'h046681E5, 32'hD4BF5D30};
        tbl[2] = '{32'h01010101, 32'h01010101};
        tbl[3] = '{32'h00000000, 32'h00000000};
        for (int i = 4; i < 6; i++) begin
            tbl[i].c = $urandom;
            tbl[i].e = inv_mix(tbl[i].c);
        end

        RST = 1'b1;
        In_Valid = 1'b1;
        In_Column = 32'hFFFFFFFF;
        Out_Ready = 1'b1;
        tick;
        tick;
        chk("reset_in_ready", In_Ready, 1);
        chk("reset_out_valid", Out_Valid, 0);
        chk("reset_out_column", Out_Column, 0);
        chk("reset_enables", {en14, en11, en13, en9}, 4'h0);
        chk("reset_addresses", {a14, a11, a13, a9}, 0);
        In_Valid = 1'b0;
        RST = 1'b0;
        tick;

        for (int v = 0; v < 6; v++) begin
            send(tbl[v].c, tbl[v].e);
            pop_check;
            tick;
            chk("out_valid_drop", Out_Valid, 0);
            chk("in_ready_after", In_Ready, 1);
        end

        Out_Ready = 1'b0;
        send(tbl[1].c, tbl[1].e);
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", Out_Valid, 1);
            chk("bp_out_column", Out_Column, tbl[1].e);
            chk("bp_in_ready", In_Ready, 0);
            In_Valid = i[0];
            In_Column = $urandom;
            tick;
        end
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        pop_check;
        tick;
        chk("bp_release", Out_Valid, 0);
        chk("bp_column_held", Out_Column, tbl[1].e);

        In_Valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            In_Column = tbl[j + 3].c;
            w = 0;
            while (!In_Ready && w < 20) begin
                tick;
                w++;
            end
            chk("b2b_accept_wait", w < 20, 1);
            tick;
            acc[j] = cyc;
            exp_q.push_back(tbl[j + 3].e);
            w = 0;
            while (!Out_Valid && w < 20) begin
                tick;
                w++;
            end
            chk("b2b_out_wait", w < 20, 1);
            pop_check;
            tick;
        end
        In_Valid = 1'b0;
        chk("b2b_spacing_01", acc[1] - acc[0], 7);
        chk("b2b_spacing_12", acc[2] - acc[1], 7);

        In_Valid = 1'b1;
        In_Column = tbl[0].c;
        tick;
        In_Valid = 1'b0;
        tick;
        tick;
        chk("rst_row2_enables", {en14, en11, en13, en9}, 4'hf);
        chk("rst_row2_address", {a14, a11, a13, a9}, rotl(tbl[0].c, 2));
        RST = 1'b1;
        #1;
        chk("rst_enables_now", {en14, en11, en13, en9}, 4'h0);
        chk("rst_addresses_now", {a14, a11, a13, a9}, 0);
        chk("rst_out_valid_now", Out_Valid, 0);
        chk("rst_in_ready_now", In_Ready, 1);
        tick;
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("rst_no_result", Out_Valid, 0);
            tick;
        end
        send(tbl[1].c, tbl[1].e);
        pop_check;
        tick;
        chk("rst_recover_drop", Out_Valid, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
